// File: rtl/melody_pkg.sv
// Shared types and tone table for the melody sequencer.
// Holds the note width, FSM state enum and half-period lookup.
package melody_pkg;

  localparam int NOTE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    GAP
  } state_t;

  // Half-period of each pitch in clk cycles; code 0 is a rest.
  function automatic logic [15:0] half_of(
    input logic [NOTE_W-1:0] n
  );
    logic [15:0] h;
    case (n)
      4'd1:    h = 16'd47778;
      4'd2:    h = 16'd42566;
      4'd3:    h = 16'd37922;
      4'd4:    h = 16'd35793;
      4'd5:    h = 16'd31888;
      4'd6:    h = 16'd28409;
      4'd7:    h = 16'd25310;
      4'd8:    h = 16'd23889;
      4'd9:    h = 16'd21283;
      4'd10:   h = 16'd18961;
      4'd11:   h = 16'd17897;
      4'd12:   h = 16'd15944;
      4'd13:   h = 16'd14205;
      4'd14:   h = 16'd12655;
      4'd15:   h = 16'd11945;
      default: h = 16'd0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: clk, rst_n, note[3:0] in; beep out.
// Each half-period is half_of(note)+1 cycles, phase-reset on note change.
module tone_gen
  import melody_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NOTE_W-1:0] note,
  output logic              beep
);

  logic [NOTE_W-1:0] note_q;
  logic [15:0]       cnt;
  logic              beep_q;
  logic              chg;
  logic [15:0]       half;
  logic [15:0]       base;
  logic              lvl;

  // A changed note counts as cycle 0 of a fresh, low half-period.
  always_comb begin
    half = half_of(note);
    chg  = (note != note_q);
    base = chg ? 16'd0 : cnt;
    lvl  = chg ? 1'b0 : beep_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q <= '0;
      cnt    <= '0;
      beep_q <= 1'b0;
    end else begin
      note_q <= note;
      if (note == '0) begin
        cnt    <= '0;
        beep_q <= 1'b0;
      end else if (base == half) begin
        cnt    <= '0;
        beep_q <= ~lvl;
      end else begin
        cnt    <= base + 16'd1;
        beep_q <= lvl;
      end
    end
  end

  assign beep = beep_q & ~chg & (note != '0);

endmodule

// File: rtl/melody_seq.sv
// Programmable melody sequencer: song table, NOTE/GAP FSM, tone output.
// In: wr_* table writes, song_len, start/stop/loop. Out: busy, done, cur_idx, note_out, beep.
module melody_seq
  import melody_pkg::*;
#(
  parameter  int DEPTH    = 64,
  parameter  int TICK_DIV = 5000000,
  parameter  int GAP_DIV  = 500000,
  parameter  int DUR_W    = 4,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic [AW:0]       song_len,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     cur_idx,
  output logic [NOTE_W-1:0] note_out,
  output logic              beep
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_DIV > 1) ? $clog2(GAP_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_DIV - 1);

  logic [NOTE_W-1:0] tbl_note [DEPTH];
  logic [DUR_W-1:0]  tbl_dur  [DEPTH];

  state_t            state, state_n;
  logic [AW-1:0]     idx_n;
  logic [NOTE_W-1:0] note_n;
  logic [DUR_W-1:0]  dur_left, dur_n;
  logic [TW-1:0]     tick_cnt, tick_n;
  logic [GW-1:0]     gap_cnt, gap_n;
  logic [AW:0]       len, len_n;
  logic              done_n;
  logic              ld;
  logic [DUR_W-1:0]  ld_dur;
  logic [AW:0]       idx_p1;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_note[wr_addr] <= wr_note;
      tbl_dur[wr_addr]  <= wr_dur;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = cur_idx;
    note_n  = note_out;
    dur_n   = dur_left;
    tick_n  = tick_cnt;
    gap_n   = gap_cnt;
    len_n   = len;
    done_n  = 1'b0;
    ld      = 1'b0;
    ld_dur  = '0;
    idx_p1  = {1'b0, cur_idx} + (AW+1)'(1);
    unique case (state)
      IDLE: begin
        if (start && !stop && song_len != '0) begin
          len_n   = song_len;
          idx_n   = '0;
          ld      = 1'b1;
          state_n = NOTE;
        end
      end
      NOTE: begin
        if (stop) begin
          state_n = IDLE;
        end else if (tick_cnt == TICK_LAST) begin
          tick_n = '0;
          if (dur_left == DUR_W'(1)) begin
            note_n  = '0;
            gap_n   = '0;
            state_n = GAP;
          end else begin
            dur_n = dur_left - DUR_W'(1);
          end
        end else begin
          tick_n = tick_cnt + TW'(1);
        end
      end
      GAP: begin
        if (stop) begin
          state_n = IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          gap_n = '0;
          if (idx_p1 < len) begin
            idx_n   = cur_idx + AW'(1);
            ld      = 1'b1;
            state_n = NOTE;
          end else if (loop) begin
            idx_n   = '0;
            ld      = 1'b1;
            state_n = NOTE;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // Abort clears everything back to an idle, silent state.
    if (stop && state != IDLE) begin
      idx_n  = '0;
      note_n = '0;
      dur_n  = '0;
      tick_n = '0;
      gap_n  = '0;
    end
    if (ld) begin
      ld_dur = tbl_dur[idx_n];
      note_n = tbl_note[idx_n];
      dur_n  = (ld_dur == '0) ? DUR_W'(1) : ld_dur;
      tick_n = '0;
      gap_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_idx  <= '0;
      note_out <= '0;
      dur_left <= '0;
      tick_cnt <= '0;
      gap_cnt  <= '0;
      len      <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cur_idx  <= idx_n;
      note_out <= note_n;
      dur_left <= dur_n;
      tick_cnt <= tick_n;
      gap_cnt  <= gap_n;
      len      <= len_n;
      done     <= done_n;
    end
  end

  assign busy = (state != IDLE);

  tone_gen u_tone (
    .clk   (clk),
    .rst_n (rst_n),
    .note  (note_out),
    .beep  (beep)
  );

endmodule

// File: tb/tb_melody_seq.sv
// Scoreboard bench for melody_seq: per-cycle expected frames from a song model.
// A second instance with a long tick checks the tone waveform.
module tb_melody_seq;

  localparam int T  = 10;
  localparam int G  = 3;
  localparam int D  = 8;
  localparam int T2 = 2000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_note = '0;
  logic [3:0] wr_dur = '0;
  logic [3:0] song_len = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic       busy, done, beep;
  logic [2:0] cur_idx;
  logic [3:0] note_out;

  logic       t_rst_n = 1'b1;
  logic       t_wr_en = 1'b0;
  logic [2:0] t_wr_addr = '0;
  logic [3:0] t_wr_note = '0;
  logic [3:0] t_wr_dur = '0;
  logic [3:0] t_len = '0;
  logic       t_start = 1'b0;
  logic       t_stop = 1'b0;
  logic       t_loop = 1'b0;
  logic       t_busy, t_done, t_beep;
  logic [2:0] t_idx;
  logic [3:0] t_note;

  melody_seq #(.DEPTH(D), .TICK_DIV(T), .GAP_DIV(G), .DUR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_note(wr_note), .wr_dur(wr_dur), .song_len(song_len),
    .start(start), .stop(stop), .loop(loop), .busy(busy), .done(done),
    .cur_idx(cur_idx), .note_out(note_out), .beep(beep)
  );

  melody_seq #(.DEPTH(D), .TICK_DIV(T2), .GAP_DIV(G), .DUR_W(4)) dut_t (
    .clk(clk), .rst_n(t_rst_n), .wr_en(t_wr_en), .wr_addr(t_wr_addr),
    .wr_note(t_wr_note), .wr_dur(t_wr_dur), .song_len(t_len),
    .start(t_start), .stop(t_stop), .loop(t_loop), .busy(t_busy),
    .done(t_done), .cur_idx(t_idx), .note_out(t_note), .beep(t_beep)
  );

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b1;

  int HALF [16] = '{0, 47778, 42566, 37922, 35793, 31888, 28409, 25310,
                    23889, 21283, 18961, 17897, 15944, 14205, 12655, 11945};

  typedef struct {
    int note;
    int busy;
    int done;
    int idx;
    int beep;
  } frame_t;

  frame_t q[$];
  int m_note [D];
  int m_dur  [D];

  function automatic void push_frame(int n, int b, int dn, int i, int bp);
    frame_t f;
    f.note = n; f.busy = b; f.done = dn; f.idx = i; f.beep = bp;
    q.push_back(f);
  endfunction

  // One pass through the song as the listener would hear it.
  function automatic void push_pass(int len, bit fin);
    for (int i = 0; i < len; i++) begin
      int n = m_note[i];
      int d = (m_dur[i] == 0) ? 1 : m_dur[i];
      for (int k = 0; k < d * T; k++)
        push_frame(n, 1, 0, i, (n == 0) ? 0 : ((k / (HALF[n] + 1)) % 2));
      for (int g = 0; g < G; g++)
        push_frame(0, 1, 0, i, 0);
    end
    if (fin) push_frame(0, 0, 1, -1, 0);
  endfunction

  always @(negedge clk) begin : monitor
    frame_t f;
    bit ok;
    if (rst_n && mon_on) begin
      if (q.size() != 0) begin
        f  = q.pop_front();
        ok = int'(note_out) == f.note && int'(busy) == f.busy &&
             int'(done) == f.done && int'(beep) == f.beep &&
             (f.idx < 0 || int'(cur_idx) == f.idx);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL frame t=%0t got note=%0d busy=%0d done=%0d idx=%0d beep=%0d want note=%0d busy=%0d done=%0d idx=%0d beep=%0d",
                   $time, note_out, busy, done, cur_idx, beep,
                   f.note, f.busy, f.done, f.idx, f.beep);
        end
      end else begin
        checks++;
        if (busy || done || note_out != 0 || beep) begin
          errors++;
          $display("FAIL idle t=%0t got busy=%0d done=%0d note=%0d beep=%0d want all 0",
                   $time, busy, done, note_out, beep);
        end
      end
    end
  end

  task automatic wr(int a, int n, int d);
    @(negedge clk); #1;
    wr_en = 1'b1; wr_addr = 3'(a); wr_note = 4'(n); wr_dur = 4'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
    m_note[a] = n; m_dur[a] = d;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain timeout left=%0d want 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic kick(int len, int extra);
    int s0, pl;
    song_len = 4'(len);
    loop = (extra > 0);
    @(negedge clk); #1;
    start = 1'b1;
    pl = 0;
    for (int p = 0; p <= extra; p++) begin
      s0 = q.size();
      push_pass(len, p == extra);
      pl = q.size() - s0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (extra > 0) begin
      int n = 0;
      while (q.size() > pl - 2 && n < 20000) begin
        @(negedge clk);
        n++;
      end
      #1 loop = 1'b0;
      checks++;
      if (q.size() > pl - 2) begin
        errors++;
        $display("FAIL loop_wait left=%0d want <=%0d", q.size(), pl - 2);
      end
    end
  endtask

  task automatic play(int len, int extra);
    kick(len, extra);
    drain(20000);
  endtask

  task automatic abort_now();
    @(negedge clk); #1;
    stop = 1'b1; start = 1'b1;
    q.delete();
    push_frame(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    stop = 1'b0; start = 1'b0;
    drain(100);
  endtask

  task automatic main_test();
    bit ok;
    int nn, nd;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    ok = !busy && !done && cur_idx == 0 && note_out == 0 && !beep;
    if (!ok) begin
      errors++;
      $display("FAIL reset_state got busy=%0d done=%0d idx=%0d note=%0d beep=%0d want 0",
               busy, done, cur_idx, note_out, beep);
    end
    #10 rst_n = 1'b1;
    wr(0, 5, 2); wr(1, 0, 1); wr(2, 15, 1);
    play(3, 0);
    song_len = 4'd0;
    @(negedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    wr(0, 7, 0);
    play(1, 0);
    wr(0, 3, 1); wr(1, 9, 2);
    play(2, 2);
    wr(0, 4, 3); wr(1, 6, 1); wr(2, 2, 2);
    kick(3, 0);
    repeat (5) @(negedge clk);
    abort_now();
    wr(0, 8, 1);
    kick(3, 0);
    repeat (11) @(negedge clk);
    abort_now();
    kick(3, 0);
    repeat (7) @(negedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain(2000);
    song_len = 4'd2;
    loop = 1'b0;
    @(negedge clk); #1;
    start = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_note = 4'd13; wr_dur = 4'd2;
    push_pass(2, 1);
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    m_note[0] = 13; m_dur[0] = 2;
    drain(2000);
    play(1, 0);
    for (int s = 0; s < 6; s++) begin
      int len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        nn = $urandom_range(0, 15);
        nd = $urandom_range(0, 4);
        wr(i, nn, nd);
      end
      play(len, $urandom_range(0, 1));
    end
    wr(0, 11, 3); wr(1, 0, 2); wr(2, 1, 1);
    kick(3, 0);
    repeat (15) @(negedge clk);
    #3 rst_n = 1'b0;
    q.delete();
    #1;
    checks++;
    ok = !busy && !done && cur_idx == 0 && note_out == 0 && !beep;
    if (!ok) begin
      errors++;
      $display("FAIL async_reset got busy=%0d done=%0d idx=%0d note=%0d beep=%0d want 0",
               busy, done, cur_idx, note_out, beep);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    play(3, 0);
  endtask

  task automatic t_wr(int a, int n, int d);
    @(negedge clk); #1;
    t_wr_en = 1'b1; t_wr_addr = 3'(a); t_wr_note = 4'(n); t_wr_dur = 4'(d);
    @(posedge clk); #1;
    t_wr_en = 1'b0;
  endtask

  task automatic t_wait(int n);
    int c = 0;
    @(negedge clk);
    while (int'(t_note) != n && c < 20) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (int'(t_note) != n) begin
      errors++;
      $display("FAIL tone_wait got note=%0d want %0d", t_note, n);
    end
  endtask

  task automatic tone_run(int n, int len);
    int mism = 0;
    int first = -1;
    for (int k = 0; k < len; k++) begin
      if (int'(t_beep) != (k / (HALF[n] + 1)) % 2 || int'(t_note) != n)
        mism++;
      if (first < 0 && t_beep) first = k;
      @(negedge clk);
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL tone_wave n=%0d bad_cycles=%0d want 0", n, mism);
    end
    checks++;
    if (first != HALF[n] + 1) begin
      errors++;
      $display("FAIL tone_first_edge n=%0d got %0d want %0d", n, first, HALF[n] + 1);
    end
    checks++;
    if (t_note != 0 || t_beep) begin
      errors++;
      $display("FAIL tone_end got note=%0d beep=%0d want 0", t_note, t_beep);
    end
  endtask

  task automatic tone_test();
    #1 t_rst_n = 1'b0;
    #10 t_rst_n = 1'b1;
    t_wr(0, 15, 15);
    t_wr(1, 12, 9);
    t_len = 4'd2;
    @(negedge clk); #1 t_start = 1'b1;
    @(posedge clk); #1 t_start = 1'b0;
    t_wait(15);
    tone_run(15, 15 * T2);
    t_wait(12);
    tone_run(12, 9 * T2);
  endtask

  initial begin
    fork
      main_test();
      tone_test();
    join
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
